// File: rtl/decrypt_arbiter_if.sv
// decrypt_arbiter_if: bundles the two requester handshakes, the datapath
// drive/return pair, the backpressured output handshake and the status
// outputs of decrypt_arbiter.
//   slave  - the arbiter side (decrypt_arbiter ports)
//   master - the environment side (requesters, datapath stub, consumer)
interface decrypt_arbiter_if;
  // Requester 0: [77:17] ciphertext, [16:6] key, [5:0] header
  logic        req0_valid;
  logic [77:0] req0_data;
  logic        req0_ready;
  // Requester 1: same layout as requester 0
  logic        req1_valid;
  logic [77:0] req1_data;
  logic        req1_ready;
  // Shared combinational decrypt datapath
  logic [77:0] dp_data;
  logic [59:0] dp_result;
  // Result handshake
  logic        out_valid;
  logic        out_ready;
  logic [59:0] out_data;
  logic        out_src;
  // Status
  logic        busy;
  logic [15:0] done_cnt;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, dp_result, out_ready,
    output req0_ready, req1_ready, dp_data, out_valid, out_data, out_src,
           busy, done_cnt
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, dp_result, out_ready,
    input  req0_ready, req1_ready, dp_data, out_valid, out_data, out_src,
           busy, done_cnt
  );
endinterface

// File: rtl/decrypt_arbiter.sv
// decrypt_arbiter: sequences packets from two requesters through the shared
// combinational decrypt datapath. One packet is accepted in IDLE, held on
// dp_data for DP_LAT cycles (WAIT), then the plaintext is captured and
// offered on the output handshake until consumed (HOLD).
//
// Build option: define DEC_ARB_RR_EN for round-robin arbitration between the
// requesters; without it requester 0 has fixed priority over requester 1.
module decrypt_arbiter #(
  parameter int unsigned DP_LAT = 1  // settle cycles, 1..15
) (
  input  logic             Clk,
  input  logic             Rst_n,
  decrypt_arbiter_if.slave bus
);

  if (DP_LAT < 1 || DP_LAT > 15) begin : g_bad_dp_lat
    $error("decrypt_arbiter: DP_LAT must be within 1..15");
  end

  localparam logic [3:0] LAT_M1 = 4'(DP_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic [77:0] dp_data_q,   dp_data_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic        src_q,       src_d;
  logic        out_valid_q, out_valid_d;
  logic [59:0] out_data_q,  out_data_d;
  logic        out_src_q,   out_src_d;
  logic        busy_q,      busy_d;
  logic [15:0] done_cnt_q,  done_cnt_d;

  logic grant0;   // requester 0 wins if the arbiter is open
  logic grant1;   // requester 1 wins if the arbiter is open
  logic open;     // arbiter may accept this cycle
  logic accept;   // a packet transfers at the coming edge
  logic win_idx;  // index of the accepted requester

`ifdef DEC_ARB_RR_EN
  logic ptr_q, ptr_d;  // favoured requester on contention

  // Round-robin: the pointer only matters when both requesters are valid
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = ~ptr_q;
      grant1 = ptr_q;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  // Pointer moves to the requester that just lost (or was absent)
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ~win_idx;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: requester 0 always beats requester 1
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid && !bus.req0_valid;
  end
`endif

  // NOTE: ready is combinational from state_q, which already reads IDLE while
  // reset is held; gating with Rst_n keeps both readies low during reset so no
  // requester believes a packet was taken that the flops then discard.
  assign open           = (state_q == IDLE) && Rst_n;
  assign bus.req0_ready = open && grant0;
  assign bus.req1_ready = open && grant1;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign win_idx        = grant1;

  // Next-state and next-output computation for the sequencing FSM
  always_comb begin
    // NOTE: every variable gets its hold value first so that no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    dp_data_d   = dp_data_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    done_cnt_d  = done_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dp_data_d = win_idx ? bus.req1_data : bus.req0_data;
          src_d     = win_idx;
          cnt_d     = LAT_M1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          out_data_d  = bus.dp_result;
          out_src_d   = src_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      dp_data_q   <= '0;
      cnt_q       <= '0;
      src_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the values from
      // before the edge, independent of statement order.
      state_q     <= state_d;
      dp_data_q   <= dp_data_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign bus.dp_data   = dp_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = busy_q;
  assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_decrypt_arbiter.sv
// tb_decrypt_arbiter: scoreboard bench for decrypt_arbiter. Two instances are
// built, DP_LAT=1 (dut1) and DP_LAT=4 (dut4). Expected results are queued
// when stimulus is issued and popped by per-instance monitors on every output
// handshake. Inputs change 1-2 ns after the rising edge; outputs are sampled
// on the falling edge.
module tb_decrypt_arbiter;

  typedef struct packed {
    logic        src;
    logic [59:0] data;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  decrypt_arbiter_if bus1 ();
  decrypt_arbiter_if bus4 ();

  // Datapath stub: either a fixed value or the ciphertext's top 60 bits
  logic        stub_const;
  logic [59:0] stub_val;
  assign bus1.dp_result = stub_const ? stub_val : bus1.dp_data[77:18];
  assign bus4.dp_result = bus4.dp_data[77:18];

  decrypt_arbiter #(.DP_LAT(1)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1));
  decrypt_arbiter #(.DP_LAT(4)) dut4 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        exp1[$];
  exp_t        exp4[$];
  logic [77:0] q0[$];
  logic [77:0] q1[$];
  bit          drv_en = 1'b0;

  task automatic check(input string name, input logic [79:0] act,
                       input logic [79:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [77:0] mk_pkt(input logic s, input int i);
    logic [31:0] iv;
    iv = 32'(i);
    mk_pkt = {16'hC0DE, 3'b000, s, iv[7:0], iv ^ 32'h1234_5678, 18'h2A5A5};
  endfunction

  function automatic exp_t mk_exp(input logic s, input logic [77:0] pkt);
    mk_exp.src  = s;
    mk_exp.data = pkt[77:18];
  endfunction

  // Requester driver for dut1: presents the head of each queue, pops on accept
  initial begin : req_driver
    bit acc0;
    bit acc1;
    forever begin
      @(negedge Clk);
      acc0 = bus1.req0_valid && bus1.req0_ready;
      acc1 = bus1.req1_valid && bus1.req1_ready;
      @(posedge Clk);
      #2;
      if (drv_en) begin
        if (acc0 && q0.size() != 0) void'(q0.pop_front());
        if (acc1 && q1.size() != 0) void'(q1.pop_front());
        bus1.req0_valid = (q0.size() != 0);
        bus1.req0_data  = (q0.size() != 0) ? q0[0] : '0;
        bus1.req1_valid = (q1.size() != 0);
        bus1.req1_data  = (q1.size() != 0) ? q1[0] : '0;
      end
    end
  end

  // Scoreboard monitor for dut1
  initial begin : monitor1
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && bus1.out_valid && bus1.out_ready) begin
        check("sb1_expected_pending", exp1.size() != 0, 1'b1);
        if (exp1.size() != 0) begin
          e = exp1.pop_front();
          check("sb1_out_src", bus1.out_src, e.src);
          check("sb1_out_data", bus1.out_data, e.data);
        end
      end
    end
  end

  // Scoreboard monitor for dut4
  initial begin : monitor4
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && bus4.out_valid && bus4.out_ready) begin
        check("sb4_expected_pending", exp4.size() != 0, 1'b1);
        if (exp4.size() != 0) begin
          e = exp4.pop_front();
          check("sb4_out_src", bus4.out_src, e.src);
          check("sb4_out_data", bus4.out_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  // Waits until dut1 has drained all queued work, bounded by budget cycles
  task automatic wait_idle1(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((q0.size() != 0 || q1.size() != 0 || exp1.size() != 0 ||
                bus1.busy) && n < budget);
    check("drain1_in_budget", (q0.size() == 0 && q1.size() == 0 &&
                               exp1.size() == 0 && !bus1.busy), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    Rst_n           = 1'b0;
    drv_en          = 1'b0;
    q0.delete();
    q1.delete();
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    bus4.req0_valid = 1'b0;
    bus4.req1_valid = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  initial begin : main
    logic [77:0] p;
    logic [77:0] pa;
    logic [77:0] pb;
    logic [77:0] px;
    logic [77:0] py;
    logic [77:0] pz;
    int          n;
    int          rises;

    Rst_n           = 1'b0;
    stub_const      = 1'b0;
    stub_val        = '0;
    bus1.req0_valid = 1'b0;
    bus1.req0_data  = '0;
    bus1.req1_valid = 1'b0;
    bus1.req1_data  = '0;
    bus1.out_ready  = 1'b1;
    bus4.req0_valid = 1'b0;
    bus4.req0_data  = '0;
    bus4.req1_valid = 1'b0;
    bus4.req1_data  = '0;
    bus4.out_ready  = 1'b1;

    // ---- Reset with both valids high ----
    pa = mk_pkt(1'b0, 1);
    pb = mk_pkt(1'b1, 1);
    q0.push_back(pa);
    q1.push_back(pb);
    exp1.push_back(mk_exp(1'b0, pa));
    exp1.push_back(mk_exp(1'b1, pb));
    bus1.req0_valid = 1'b1;
    bus1.req0_data  = pa;
    bus1.req1_valid = 1'b1;
    bus1.req1_data  = pb;
    bus4.req0_valid = 1'b1;
    bus4.req1_valid = 1'b1;
    drv_en          = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_req0_ready", bus1.req0_ready, 1'b0);
    check("rst_req1_ready", bus1.req1_ready, 1'b0);
    check("rst_dp_data", bus1.dp_data, 78'h0);
    check("rst_out_valid", bus1.out_valid, 1'b0);
    check("rst_out_data", bus1.out_data, 60'h0);
    check("rst_out_src", bus1.out_src, 1'b0);
    check("rst_busy", bus1.busy, 1'b0);
    check("rst_done_cnt", bus1.done_cnt, 16'h0);
    check("rst_dut4_readies", {bus4.req0_ready, bus4.req1_ready}, 2'b00);
    @(posedge Clk);
    #1;
    bus4.req0_valid = 1'b0;
    bus4.req1_valid = 1'b0;
    Rst_n           = 1'b1;
    @(negedge Clk);
    check("rst_first_grant_req0", bus1.req0_ready, 1'b1);
    check("rst_first_grant_not_req1", bus1.req1_ready, 1'b0);
    wait_idle1(50);
    check("rst_done_cnt_after", bus1.done_cnt, 16'd2);

    // ---- Single packet, DP_LAT=1 ----
    do_reset();
    stub_const = 1'b1;
    stub_val   = 60'h123;
    p = 78'h3FFF_0000_0000_0000_0A5;
    exp1.push_back('{src: 1'b0, data: 60'h123});
    bus1.req0_data  = p;
    bus1.req0_valid = 1'b1;
    @(negedge Clk);
    check("single_ready_offered", bus1.req0_ready, 1'b1);
    @(posedge Clk);
    #1;
    bus1.req0_valid = 1'b0;
    @(negedge Clk);
    check("single_ready_one_cycle", bus1.req0_ready, 1'b0);
    check("single_dp_data", bus1.dp_data, p);
    check("single_out_valid_not_yet", bus1.out_valid, 1'b0);
    check("single_busy", bus1.busy, 1'b1);
    @(negedge Clk);
    check("single_out_valid_rise", bus1.out_valid, 1'b1);
    check("single_out_data", bus1.out_data, 60'h123);
    check("single_out_src", bus1.out_src, 1'b0);
    @(negedge Clk);
    check("single_out_valid_drop", bus1.out_valid, 1'b0);
    check("single_done_cnt", bus1.done_cnt, 16'd1);
    check("single_dp_data_held_idle", bus1.dp_data, p);
    check("single_busy_idle", bus1.busy, 1'b0);
    stub_const = 1'b0;

    // ---- Contention: 4 packets from each requester ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk_pkt(1'b0, i + 10));
      q1.push_back(mk_pkt(1'b1, i + 10));
    end
`ifdef DEC_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      exp1.push_back(mk_exp(1'b0, mk_pkt(1'b0, i + 10)));
      exp1.push_back(mk_exp(1'b1, mk_pkt(1'b1, i + 10)));
    end
`else
    for (int i = 0; i < 4; i++) exp1.push_back(mk_exp(1'b0, mk_pkt(1'b0, i + 10)));
    for (int i = 0; i < 4; i++) exp1.push_back(mk_exp(1'b1, mk_pkt(1'b1, i + 10)));
`endif
    drv_en = 1'b1;
    wait_idle1(200);
    check("cont_done_cnt", bus1.done_cnt, 16'd8);

    // ---- Backpressure for 10 cycles ----
    do_reset();
    px = mk_pkt(1'b0, 40);
    py = mk_pkt(1'b1, 41);
    bus1.out_ready = 1'b0;
    q0.push_back(px);
    q1.push_back(py);
    exp1.push_back(mk_exp(1'b0, px));
    exp1.push_back(mk_exp(1'b1, py));
    drv_en = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!bus1.out_valid && n < 20);
    check("bp_out_valid_seen", bus1.out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("bp_out_valid_stable", bus1.out_valid, 1'b1);
      check("bp_out_data_stable", bus1.out_data, px[77:18]);
      check("bp_out_src_stable", bus1.out_src, 1'b0);
      check("bp_readies_low", {bus1.req0_ready, bus1.req1_ready}, 2'b00);
    end
    @(posedge Clk);
    #1;
    bus1.out_ready = 1'b1;
    @(negedge Clk);
    check("bp_valid_at_release", bus1.out_valid, 1'b1);
    @(negedge Clk);
    check("bp_out_valid_dropped", bus1.out_valid, 1'b0);
    check("bp_req1_ready_next", bus1.req1_ready, 1'b1);
    check("bp_req0_ready_next", bus1.req0_ready, 1'b0);
    check("bp_busy_idle", bus1.busy, 1'b0);
    @(negedge Clk);
    check("bp_next_accept_dp_data", bus1.dp_data, py);
    check("bp_busy_again", bus1.busy, 1'b1);
    wait_idle1(50);

    // ---- DP_LAT=4 timing ----
    do_reset();
    pz = mk_pkt(1'b1, 50);
    exp4.push_back(mk_exp(1'b1, pz));
    bus4.req1_data  = pz;
    bus4.req1_valid = 1'b1;
    @(negedge Clk);
    check("lat4_req1_ready", bus4.req1_ready, 1'b1);
    check("lat4_req0_ready", bus4.req0_ready, 1'b0);
    @(posedge Clk);
    #1;
    bus4.req1_valid = 1'b0;
    bus4.req1_data  = '0;
    for (int e = 0; e <= 4; e++) begin
      @(negedge Clk);
      check("lat4_out_valid_timing", bus4.out_valid, (e == 4));
      check("lat4_dp_data_held", bus4.dp_data, pz);
    end
    @(negedge Clk);
    check("lat4_done_cnt", bus4.done_cnt, 16'd1);
    check("lat4_sb_drained", exp4.size(), 0);

    // ---- Reset during WAIT ----
    p = mk_pkt(1'b0, 60);
    @(posedge Clk);
    #1;
    bus4.req0_data  = p;
    bus4.req0_valid = 1'b1;
    @(posedge Clk);
    #1;
    bus4.req0_valid = 1'b0;
    @(negedge Clk);
    check("midwait_busy_before", bus4.busy, 1'b1);
    check("midwait_dp_data_before", bus4.dp_data, p);
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    check("midwait_async_busy", bus4.busy, 1'b0);
    check("midwait_async_dp_data", bus4.dp_data, 78'h0);
    check("midwait_async_out_valid", bus4.out_valid, 1'b0);
    check("midwait_async_done_cnt", bus4.done_cnt, 16'h0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (bus4.out_valid) rises++;
    end
    check("midwait_no_output", rises, 0);
    check("midwait_idle", bus4.busy, 1'b0);

    // ---- done_cnt wrap (counter preloaded near its limit) ----
    do_reset();
    force dut1.done_cnt_q = 16'hFFFE;
    #1;
    release dut1.done_cnt_q;
    p = mk_pkt(1'b0, 70);
    q0.push_back(p);
    exp1.push_back(mk_exp(1'b0, p));
    drv_en = 1'b1;
    wait_idle1(50);
    check("wrap_done_cnt_ffff", bus1.done_cnt, 16'hFFFF);
    p = mk_pkt(1'b1, 71);
    q1.push_back(p);
    exp1.push_back(mk_exp(1'b1, p));
    wait_idle1(50);
    check("wrap_done_cnt_zero", bus1.done_cnt, 16'h0000);

    check("final_exp1_empty", exp1.size(), 0);
    check("final_exp4_empty", exp4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
